dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder that serves load/store requests issued by the MEM stage of the 5-stage MIPS pipeline.
- Accepts one request at a time and applies byte-lane write enables.
- Inserts a configurable number of wait states and returns read data with a one-cycle ack.
- Drives a combinational busy so the hazard unit freezes F/D/E/M while a request is outstanding.

Parameters:
- ADDR_W, 12, word-index width; memory depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra wait states between acceptance and access (0..15).
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from the MEM stage.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address (ALU result of the M stage).
- wdata  in  32  store data (forwarded RT of the M stage).
- byte_we  in  4  byte-lane enables; bit i covers wdata[8i+7:8i].
- rdata  out  32  word read, or merged word written; valid while ack=1.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  pipeline stall request.
- err  out  1  illegal-request flag; valid with ack.

Behaviour:
- Reset:
  - state=IDLE, rdata=0, ack=0, err=0, wait counter=0.
  - Latched request fields are cleared.
  - All memory words are set to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at an edge: latch we, addr, wdata and byte_we; load cnt=WAIT_CYCLES; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt==0: perform the access at this edge and go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - ack=1.
  - If req=1 at this edge, accept a new request exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Latency:
  - Request sampled at edge E0 gives ack high in the cycle after edge E0+WAIT_CYCLES+1.
  - Throughput is one request per WAIT_CYCLES+2 cycles.
- busy (combinational) = (state==WAIT) | (state!=WAIT & req & !(state==RESP)).
  - In practice: high in IDLE with req, high in WAIT, low in RESP so the pipeline advances in the ack cycle.
- Word index = (addr - BASE_ADDR)[ADDR_W+1:2]; addr[1:0] is ignored for the index.
- Out of range (addr-BASE_ADDR >= 4*2^ADDR_W):
  - Writes are dropped.
  - Reads return 0.
  - err is not set unless the optional feature is enabled.
- Store:
  - Each lane with byte_we[i]=1 is replaced; other lanes are kept.
  - rdata = resulting merged word.
  - byte_we=0000 leaves memory unchanged and still acks.
- Load: rdata = stored word; byte_we is ignored.
- rdata holds its value between acks.
- Read-after-write to the same word in the next request returns the new data.
- req while in WAIT is ignored; the requester holds req/fields stable until ack.
- Reset mid-operation:
  - The request is aborted with no ack.
  - A write not yet performed, i.e. in WAIT, never reaches memory.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - A store with byte_we not in {0001,0010,0100,1000,0011,1100,1111} is illegal; out-of-range addresses are also illegal.
  - An illegal request still completes with normal latency, with err=1 in the ack cycle, the write suppressed and rdata=0.
- Undefined:
  - err is tied to 0.
  - Every mask is written as given.

Decomposition:
- Shared package (dm_pkg):
  - State enumeration IDLE/WAIT/RESP.
  - Legal byte-mask constants.
  - Default ADDR_W/BASE_ADDR constants reused by the pipeline top.
- Sub-module dm_array: synchronous 2^ADDR_W x 32 storage with 4 byte-lane write enables, a registered read port and synchronous clear-on-reset.
- dm_responder holds the FSM, counter, range check and error logic.

Test Plan:
1. WAIT_CYCLES=1; store addr=0x10, wdata=0xDEADBEEF, byte_we=1111, then load 0x10 -> acks 3 cycles after each accept; load rdata=0xDEADBEEF; busy high exactly 2 cycles per request.
2. Byte lanes: word 0x20 = 0x11223344; store wdata=0xAABBCCDD, byte_we=0100 -> load returns 0x11BB3344.
3. Back-to-back: req held high across RESP for two loads -> second accept on the first ack edge; no idle cycle; acks spaced WAIT_CYCLES+2 apart.
4. Reset asserted in WAIT of store 0x55AA55AA to 0x40 -> no ack; after reset a load of 0x40 returns 0 and rdata=0.
5. Out of range: addr=BASE_ADDR+0x4000 with ADDR_W=12; store then load -> load rdata=0; no word in range modified.
6. DM_ALIGN_CHECK_EN defined: store byte_we=0101 -> err=1 with ack, memory unchanged. Macro undefined: same store writes lanes 0 and 2, err=0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// DM_ALIGN_CHECK_EN enables illegal byte-mask / out-of-range error reporting.
package dm_pkg;

    localparam int          DM_ADDR_W    = 12;
    localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3,
            BE_H0, BE_H1, BE_W: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-addressed storage with byte-lane writes, registered read port
// and synchronous clear of every word on reset.
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_q;
    logic [31:0] rd_d;

    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/dm_responder.sv
// MEM-stage data-memory responder: one request at a time, wait states, ack pulse.
// Optional DM_ALIGN_CHECK_EN flags illegal masks / ranges on err.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W      = DM_ADDR_W,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_we,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;

    logic              accept;
    logic              access;
    logic              in_range;
    logic              blocked;
    logic [31:0]       off;
    logic [31:0]       rd_off;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       arr_rd;
    logic [31:0]       merged;
    logic              wr_en;

    assign accept = req & ((state_q == IDLE) | (state_q == RESP));
    assign access = (state_q == WAIT) & (cnt_q == 4'd0);

    assign off      = addr_q - BASE_ADDR;
    assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
    assign idx      = ADDR_W'(off >> 2);

    // Read is launched on the accept edge so the old word is ready at access.
    assign rd_off = addr_d - BASE_ADDR;
    assign rd_idx = ADDR_W'(rd_off >> 2);

`ifdef DM_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign blocked = ~in_range | (we_q & ~be_legal(be_q));
`else
    assign blocked = ~in_range;
`endif

    always_comb begin
        merged = arr_rd;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    assign wr_en = access & we_q & ~blocked;

    dm_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_be   (be_q),
        .wr_idx  (idx),
        .wr_data (wdata_q),
        .rd_en   (accept),
        .rd_idx  (rd_idx),
        .rd_data (arr_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = WAIT;
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
            RESP: state_d = req ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        if (accept) begin
            cnt_d   = CNT_INIT;
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
            be_d    = byte_we;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (access) begin
            if (blocked) begin
                rdata_d = '0;
            end else begin
                rdata_d = we_q ? merged : arr_rd;
            end
        end
    end

    always_comb begin
        ack  = (state_q == RESP);
        busy = (state_q == WAIT)
             | ((state_q != WAIT) & req & (state_q != RESP));
    end

    assign rdata = rdata_q;

`ifdef DM_ALIGN_CHECK_EN
    assign err_d = access & blocked;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (WAIT_CYCLES=1, ADDR_W=12).
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_we;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    int tests;
    int fails;

    int          lat;
    int          bcnt;
    logic [31:0] rd_ack;
    logic        err_ack;
    logic        busy_ack;

    dm_responder #(
        .ADDR_W      (12),
        .WAIT_CYCLES (1),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .byte_we (byte_we),
        .rdata   (rdata),
        .ack     (ack),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req     = 1'b1;
        we      = w;
        addr    = a;
        wdata   = d;
        byte_we = be;
    endtask

    // Counts negedges after an accept edge until ack, bounded.
    task automatic wait_ack();
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ack) break;
            if (busy) bcnt++;
        end while (lat < 20);
        rd_ack   = rdata;
        err_ack  = err;
        busy_ack = busy;
    endtask

    // Single transaction from a negedge in IDLE back to a negedge in IDLE.
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        drive(w, a, d, be);
        @(posedge clk);
        wait_ack();
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        byte_we = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Full-word store then load
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
        #1;
        chk("idle_req_busy", 32'(busy), 32'h1);
        @(posedge clk);
        wait_ack();
        req = 1'b0;
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_busy_cnt", 32'(bcnt), 32'd2);
        chk("st_rdata", rd_ack, 32'hDEAD_BEEF);
        chk("st_busy_ack", 32'(busy_ack), 32'h0);
        chk("st_err", 32'(err_ack), 32'h0);
        @(negedge clk);
        chk("hold_ack", 32'(ack), 32'h0);
        chk("hold_rdata", rdata, 32'hDEAD_BEEF);
        xact(1'b0, 32'h10, 32'h0, 4'b0000);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_busy_cnt", 32'(bcnt), 32'd2);
        chk("ld_rdata", rd_ack, 32'hDEAD_BEEF);
        xact(1'b0, 32'h13, 32'h0, 4'b1111);
        chk("ld_lowbits", rd_ack, 32'hDEAD_BEEF);

        // Byte lanes
        xact(1'b1, 32'h20, 32'h1122_3344, 4'b1111);
        xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0100);
        chk("lane_merge", rd_ack, 32'h11BB_3344);
        xact(1'b0, 32'h20, 32'h0, 4'b0000);
        chk("lane_ld", rd_ack, 32'h11BB_3344);
        xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
        chk("be0_rdata", rd_ack, 32'h11BB_3344);
        chk("be0_lat", 32'(lat), 32'd3);

        // Back-to-back loads with req held across RESP
        xact(1'b1, 32'h24, 32'hCAFE_F00D, 4'b1111);
        drive(1'b0, 32'h10, 32'h0, 4'b0000);
        @(posedge clk);
        wait_ack();
        chk("b2b_lat1", 32'(lat), 32'd3);
        chk("b2b_rd1", rd_ack, 32'hDEAD_BEEF);
        drive(1'b0, 32'h24, 32'h0, 4'b0000);
        @(posedge clk);
        wait_ack();
        req = 1'b0;
        chk("b2b_lat2", 32'(lat), 32'd3);
        chk("b2b_busy2", 32'(bcnt), 32'd2);
        chk("b2b_rd2", rd_ack, 32'hCAFE_F00D);
        @(negedge clk);

        // Reset during WAIT of a store
        drive(1'b1, 32'h40, 32'h55AA_55AA, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b0;
        chk("mid_ack", 32'(ack), 32'h0);
        chk("mid_rdata", rdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_noack", 32'(ack), 32'h0);
        end
        xact(1'b0, 32'h40, 32'h0, 4'b0000);
        chk("mid_ld40", rd_ack, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'b0000);
        chk("mid_ld10", rd_ack, 32'h0);

        // Out of range
        xact(1'b1, 32'h0, 32'h0BAD_F00D, 4'b1111);
        xact(1'b1, 32'h10, 32'h1234_5678, 4'b1111);
        xact(1'b1, 32'h4000, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_st_lat", 32'(lat), 32'd3);
`ifdef DM_ALIGN_CHECK_EN
        chk("oor_st_err", 32'(err_ack), 32'h1);
        chk("oor_st_rdata", rd_ack, 32'h0);
`else
        chk("oor_st_err", 32'(err_ack), 32'h0);
`endif
        xact(1'b0, 32'h4000, 32'h0, 4'b0000);
        chk("oor_ld", rd_ack, 32'h0);
        xact(1'b0, 32'h0, 32'h0, 4'b0000);
        chk("oor_w0", rd_ack, 32'h0BAD_F00D);
        xact(1'b0, 32'h10, 32'h0, 4'b0000);
        chk("oor_w4", rd_ack, 32'h1234_5678);

        // Non-contiguous mask
        xact(1'b1, 32'h20, 32'h1122_3344, 4'b1111);
        xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        chk("mask_lat", 32'(lat), 32'd3);
`ifdef DM_ALIGN_CHECK_EN
        chk("mask_err", 32'(err_ack), 32'h1);
        chk("mask_rdata", rd_ack, 32'h0);
        chk("mask_err_clr", 32'(err), 32'h0);
        xact(1'b0, 32'h20, 32'h0, 4'b0000);
        chk("mask_ld", rd_ack, 32'h1122_3344);
`else
        chk("mask_err", 32'(err_ack), 32'h0);
        chk("mask_rdata", rd_ack, 32'h11BB_33DD);
        xact(1'b0, 32'h20, 32'h0, 4'b0000);
        chk("mask_ld", rd_ack, 32'h11BB_33DD);
`endif
        chk("ld_err", 32'(err_ack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
